fetch_decode_core: RTL and testbench

- Front-end of the ARM-subset five-stage pipeline.
- Holds the program counter, computes PC+4, and decodes the instruction latched in IF/ID into the control word consumed downstream by the control-mux and ID/EX register.
- The PC drives instruction ROM addressing; decode is purely combinational.

---
 rtl/fetch_decode_pkg.sv | 43 ++++
 rtl/fetch_decode_core_instr_decoder.sv | 43 ++++
 rtl/fetch_decode_core.sv | 67 ++++++
 tb/tb_fetch_decode_core.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front-end.
//   - alu_op_e : ALU operation codes (ARM data-processing opcode encoding)
//   - instruction-class field constants
//   - ctrl_t   : packed control word produced by the decoder
package fetch_decode_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_EOR = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_RSB = 4'b0011,
    ALU_ADD = 4'b0100,
    ALU_ADC = 4'b0101,
    ALU_SBC = 4'b0110,
    ALU_RSC = 4'b0111,
    ALU_TST = 4'b1000,
    ALU_TEQ = 4'b1001,
    ALU_CMP = 4'b1010,
    ALU_CMN = 4'b1011,
    ALU_ORR = 4'b1100,
    ALU_MOV = 4'b1101,
    ALU_BIC = 4'b1110,
    ALU_MVN = 4'b1111
  } alu_op_e;

  // Instruction-class selectors: [27:26] for DP / load-store, [27:25] for branch.
  localparam logic [1:0] CLS_DP     = 2'b00;
  localparam logic [1:0] CLS_LS     = 2'b01;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  typedef struct packed {
    logic    rf_en;
    alu_op_e alu_op;
    logic    load;
    logic    branch;
    logic    branch_link;
    logic    s_bit;
    logic    rw;
    logic    size;
    logic    datamem_en;
  } ctrl_t;

endpackage

// File: rtl/fetch_decode_core_instr_decoder.sv
// instr_decoder: purely combinational decode of an IF/ID instruction word
// into the control word.
// Ports:
//   instruction in  [31:0]  instruction word (condition field ignored)
//   ctrl        out ctrl_t  decoded control word; all zero for NOP/unsupported
module instr_decoder
  import fetch_decode_pkg::*;
(
  input  logic [31:0] instruction,
  output ctrl_t       ctrl
);

  logic is_nop;

  // The all-zero word is an explicit NOP even though it lands in the DP class.
  assign is_nop = (instruction == 32'h0);

  always_comb begin
    ctrl = '0;
    if (!is_nop) begin
      if (instruction[27:26] == CLS_DP) begin
        ctrl.alu_op = alu_op_e'(instruction[24:21]);
        ctrl.s_bit  = instruction[20];
        // TST/TEQ/CMP/CMN (10xx) only set flags; no register write-back.
        ctrl.rf_en  = (instruction[24:23] != 2'b10);
      end else if (instruction[27:26] == CLS_LS) begin
        ctrl.datamem_en = 1'b1;
        ctrl.load       = instruction[20];
        ctrl.rf_en      = instruction[20];
        ctrl.rw         = ~instruction[20];
        ctrl.size       = instruction[22];
        // U bit picks whether the offset is added to or subtracted from the base.
        ctrl.alu_op     = instruction[23] ? ALU_ADD : ALU_SUB;
      end else if (instruction[27:25] == CLS_BRANCH) begin
        ctrl.branch      = 1'b1;
        ctrl.branch_link = instruction[24];
        ctrl.rf_en       = instruction[24];  // BL writes the return address to R14
        ctrl.alu_op      = ALU_ADD;
      end
    end
  end

endmodule

// File: rtl/fetch_decode_core.sv
// fetch_decode_core: pipeline front-end. Holds the PC, computes PC+step and
// decodes the IF/ID instruction into control signals.
// Ports:
//   clk, reset (sync, active-high)
//   le             PC load enable (0 = stall)
//   branch_taken   select branch_target as next PC
//   branch_target  redirect address
//   instruction    IF/ID instruction word
//   pc_out         current PC (ROM address = pc_out[7:0])
//   pc_plus4       pc_out + PC_STEP (combinational, wraps modulo 2^32)
//   rf_en, alu_op, load, branch, branch_link, s_bit, rw, size, datamem_en
//                  decoded control outputs (combinational)
module fetch_decode_core
  import fetch_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        le,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        rf_en,
  output logic [3:0]  alu_op,
  output logic        load,
  output logic        branch,
  output logic        branch_link,
  output logic        s_bit,
  output logic        rw,
  output logic        size,
  output logic        datamem_en
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  ctrl_t ctrl;

  assign pc_plus4 = pc_out + STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out <= RESET_PC;
    end else if (le) begin
      pc_out <= branch_taken ? branch_target : pc_plus4;
    end
  end

  instr_decoder u_decoder (
    .instruction (instruction),
    .ctrl        (ctrl)
  );

  assign rf_en       = ctrl.rf_en;
  assign alu_op      = ctrl.alu_op;
  assign load        = ctrl.load;
  assign branch      = ctrl.branch;
  assign branch_link = ctrl.branch_link;
  assign s_bit       = ctrl.s_bit;
  assign rw          = ctrl.rw;
  assign size        = ctrl.size;
  assign datamem_en  = ctrl.datamem_en;

endmodule

// File: tb/tb_fetch_decode_core.sv
// Bench for fetch_decode_core: directed vectors, expected responses queued by
// the driver, compared by an independent monitor on the falling clock edge.
module tb_fetch_decode_core;

  localparam int W = 76;  // {pc_out, pc_plus4, 12-bit control word}

  logic        clk;
  logic        reset;
  logic        le;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        rf_en;
  logic [3:0]  alu_op;
  logic        load;
  logic        branch;
  logic        branch_link;
  logic        s_bit;
  logic        rw;
  logic        size;
  logic        datamem_en;

  fetch_decode_core dut (
    .clk           (clk),
    .reset         (reset),
    .le            (le),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .rf_en         (rf_en),
    .alu_op        (alu_op),
    .load          (load),
    .branch        (branch),
    .branch_link   (branch_link),
    .s_bit         (s_bit),
    .rw            (rw),
    .size          (size),
    .datamem_en    (datamem_en)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  function automatic logic [11:0] cw(input logic rf, input logic [3:0] op,
                                     input logic ld, input logic br, input logic bl,
                                     input logic s, input logic wr, input logic sz,
                                     input logic dm);
    return {rf, op, ld, br, bl, s, wr, sz, dm};
  endfunction

  // Monitor: the DUT output is stable between edges; compare on the falling edge.
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    string        nm;
    act = {pc_out, pc_plus4, rf_en, alu_op, load, branch, branch_link,
           s_bit, rw, size, datamem_en};
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      n_checks++;
      if (act === exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got pc=%h pc4=%h ctrl=%b, expected pc=%h pc4=%h ctrl=%b",
                 nm, act[75:44], act[43:12], act[11:0], exp[75:44], exp[43:12], exp[11:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs, then take one rising edge.
  task automatic drive(input logic rst, input logic en, input logic bt,
                       input logic [31:0] tgt, input logic [31:0] instr);
    reset         = rst;
    le            = en;
    branch_taken  = bt;
    branch_target = tgt;
    instruction   = instr;
    @(posedge clk);
    #1;
  endtask

  // Queue the expected response and let the monitor compare at the next falling edge.
  task automatic expect_out(input string nm, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic [11:0] ctrl);
    exp_q.push_back({pc, pc4, ctrl});
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    string       nm;
    logic [31:0] instr;
    logic [11:0] ctrl;
  } dec_vec_t;

  dec_vec_t dec_vecs[$];

  initial begin
    reset = 1'b1; le = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; instruction = 32'h0;

    // PC: reset, increment, stall, reset priority, branch + wrap.
    drive(1, 0, 0, 32'h0, 32'h0);           expect_out("reset_pc",   32'h0, 32'h4, 12'h0);
    drive(0, 1, 0, 32'h0, 32'h0);           expect_out("inc_1",      32'h4, 32'h8, 12'h0);
    drive(0, 1, 0, 32'h0, 32'h0);           expect_out("inc_2",      32'h8, 32'hC, 12'h0);
    drive(0, 0, 1, 32'h0000_0040, 32'h0);   expect_out("stall_1",    32'h8, 32'hC, 12'h0);
    drive(0, 0, 0, 32'h0, 32'h0);           expect_out("stall_2",    32'h8, 32'hC, 12'h0);
    drive(0, 1, 0, 32'h0, 32'h0);           expect_out("inc_3",      32'hC, 32'h10, 12'h0);
    drive(1, 1, 1, 32'h0000_0100, 32'h0);   expect_out("reset_prio", 32'h0, 32'h4, 12'h0);
    drive(0, 1, 1, 32'hFFFF_FFFC, 32'h0);   expect_out("branch_top", 32'hFFFF_FFFC, 32'h0, 12'h0);
    drive(0, 1, 0, 32'h0, 32'h0);           expect_out("wrap",       32'h0, 32'h4, 12'h0);

    // Decode with PC held at 0.
    //                   rf  alu     ld br bl s  rw sz dm
    dec_vecs.push_back('{"dp_add",   32'hE082_1003, cw(1, 4'b0100, 0, 0, 0, 0, 0, 0, 0)});
    dec_vecs.push_back('{"dp_cmp",   32'hE353_0000, cw(0, 4'b1010, 0, 0, 0, 1, 0, 0, 0)});
    dec_vecs.push_back('{"dp_mov",   32'hE3A0_0001, cw(1, 4'b1101, 0, 0, 0, 0, 0, 0, 0)});
    dec_vecs.push_back('{"dp_cond0", 32'h0082_1003, cw(1, 4'b0100, 0, 0, 0, 0, 0, 0, 0)});
    dec_vecs.push_back('{"ldr",      32'hE591_2004, cw(1, 4'b0100, 1, 0, 0, 0, 0, 0, 1)});
    dec_vecs.push_back('{"strb",     32'hE5C1_2000, cw(0, 4'b0100, 0, 0, 0, 0, 1, 1, 1)});
    dec_vecs.push_back('{"ldr_u0",   32'hE511_2004, cw(1, 4'b0010, 1, 0, 0, 0, 0, 0, 1)});
    dec_vecs.push_back('{"bl",       32'hEB00_0002, cw(1, 4'b0100, 0, 1, 1, 0, 0, 0, 0)});
    dec_vecs.push_back('{"b",        32'hEA00_0002, cw(0, 4'b0100, 0, 1, 0, 0, 0, 0, 0)});
    dec_vecs.push_back('{"nop",      32'h0000_0000, 12'h0});
    dec_vecs.push_back('{"cls_100",  32'hE800_0000, 12'h0});
    dec_vecs.push_back('{"cls_11",   32'hEC00_0000, 12'h0});

    foreach (dec_vecs[i]) begin
      drive(0, 0, 0, 32'h0, dec_vecs[i].instr);
      expect_out(dec_vecs[i].nm, 32'h0, 32'h4, dec_vecs[i].ctrl);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL sb_drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
